// File: rtl/dmem_if.sv
// Request/response bus of the dmem_sync data memory.
// The par_err signal exists only when DMEM_PARITY_EN is defined.
interface dmem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              clr;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
`ifdef DMEM_PARITY_EN
  logic              par_err;
`endif

  // Load/store unit side.
  modport master (
    output clr, req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_PARITY_EN
    input  par_err,
`endif
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  // Memory side.
  modport slave (
    input  clr, req_valid, req_we, req_addr, req_wdata,
`ifdef DMEM_PARITY_EN
    output par_err,
`endif
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/dmem_sync.sv
// dmem_sync: synchronous single-port data RAM with a valid/ready request
// port, a registered one-cycle read response that never stalls, and a
// hardware clear sweep that zeroes every word after reset or on clr.
// Optional feature: define DMEM_PARITY_EN to store an even-parity bit per
// word and flag mismatches on read responses through par_err.
module dmem_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
`ifdef DMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef DMEM_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  logic [WORD_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [WORD_W-1:0] rd_word;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [WORD_W-1:0] mem_wword;

  // Next-state, array write port and read response, all from the current cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
`ifdef DMEM_PARITY_EN
    par_err_d   = 1'b0;
`endif
    mem_we      = 1'b0;
    mem_idx     = bus.req_addr[IDX_W-1:0];
    mem_wword   = '0;
    // Compared one bit wider so DEPTH = 2**ADDR_W needs no special case.
    in_range    = ({1'b0, bus.req_addr} < DEPTH_EXT);
    rd_word     = in_range ? mem[bus.req_addr[IDX_W-1:0]] : '0;

    case (state_q)
      ST_CLEAR: begin
        // Sweep writes zero data and zero parity.
        mem_we  = 1'b1;
        mem_idx = ptr_q[IDX_W-1:0];
        if (bus.clr) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        // clr wins over a simultaneous request, which is not accepted.
        if (bus.clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (bus.req_valid) begin
          if (bus.req_we) begin
            // Out-of-range writes are dropped.
            mem_we = in_range;
`ifdef DMEM_PARITY_EN
            mem_wword = {^bus.req_wdata, bus.req_wdata};
`else
            mem_wword = bus.req_wdata;
`endif
          end else begin
            // Out-of-range reads still answer, with zero data.
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd_word[DATA_W-1:0];
`ifdef DMEM_PARITY_EN
            par_err_d   = ^rd_word;
`endif
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Storage array write port.
  // NOTE: the array has no reset; the clear sweep zeroes it, so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wword;
    end
  end

  // Control and response registers.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef DMEM_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef DMEM_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.req_ready = (state_q == ST_IDLE) && !bus.clr;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef DMEM_PARITY_EN
  assign bus.par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_dmem_sync.sv
// Testbench for dmem_sync. Two instances (DEPTH=16 and DEPTH=12) receive
// identical stimulus; a per-instance array model predicts read responses,
// which a negedge monitor pops from per-instance queues and compares.
module tb_dmem_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if #(.DATA_W(8), .ADDR_W(8)) b16 ();
  dmem_if #(.DATA_W(8), .ADDR_W(8)) b12 ();

  dmem_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
  dmem_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(12)) u12 (.clk(clk), .rst(rst), .bus(b12));

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t q16[$];
  exp_t q12[$];

  // Reference model: plain word arrays plus "parity deliberately broken" flags.
  logic [7:0] ref16 [16];
  logic [7:0] ref12 [12];
  bit         bad16 [16];
  bit         bad12 [12];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [7:0] a,
                       input logic [7:0] d, input logic c);
    b16.req_valid = v;  b12.req_valid = v;
    b16.req_we    = we; b12.req_we    = we;
    b16.req_addr  = a;  b12.req_addr  = a;
    b16.req_wdata = d;  b12.req_wdata = d;
    b16.clr       = c;  b12.clr       = c;
  endtask

  task automatic model_zero();
    for (int i = 0; i < 16; i++) begin ref16[i] = 8'h00; bad16[i] = 1'b0; end
    for (int i = 0; i < 12; i++) begin ref12[i] = 8'h00; bad12[i] = 1'b0; end
  endtask

  // Applies one accepted request to the model; reads enqueue their answer.
  task automatic model_accept(input logic we, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    if (we) begin
      if (a < 16) begin ref16[a] = d; bad16[a] = 1'b0; end
      if (a < 12) begin ref12[a] = d; bad12[a] = 1'b0; end
    end else begin
      e.data = (a < 16) ? ref16[a] : 8'h00;
      e.par  = (a < 16) ? bad16[a] : 1'b0;
      q16.push_back(e);
      e.data = (a < 12) ? ref12[a] : 8'h00;
      e.par  = (a < 12) ? bad12[a] : 1'b0;
      q12.push_back(e);
    end
  endtask

  // One request per cycle: driven on the negedge, accepted on the posedge.
  task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    drive(1'b1, we, a, d, 1'b0);
    @(posedge clk);
    model_accept(we, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    end
  endtask

  // Called on a negedge where the sweep has just started at ptr 0.
  task automatic measure_busy(input int exp16, input int exp12, input string tag);
    int n16 = -1;
    int n12 = -1;
    for (int n = 0; n < 64; n++) begin
      if (n16 < 0 && b16.busy === 1'b0) n16 = n;
      if (n12 < 0 && b12.busy === 1'b0) n12 = n;
      if (n16 >= 0 && n12 >= 0) break;
      @(negedge clk);
    end
    check({tag, "_busy_cycles_d16"}, n16, exp16);
    check({tag, "_busy_cycles_d12"}, n12, exp12);
    @(negedge clk);
    check({tag, "_ready_d16"}, b16.req_ready, 1);
    check({tag, "_ready_d12"}, b12.req_ready, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},      {b16.busy, b12.busy},           2'b11);
    check({tag, "_ready"},     {b16.req_ready, b12.req_ready}, 2'b00);
    check({tag, "_rsp_valid"}, {b16.rsp_valid, b12.rsp_valid}, 2'b00);
    check({tag, "_rsp_rdata"}, {b16.rsp_rdata, b12.rsp_rdata}, 16'h0000);
`ifdef DMEM_PARITY_EN
    check({tag, "_par_err"},   {b16.par_err, b12.par_err},     2'b00);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    q16.delete();
    q12.delete();
    #1;
    check_reset_values("reset");
    @(negedge clk);
    model_zero();
    rst = 1'b0;
    measure_busy(16, 12, "reset");
  endtask

  logic pe16, pe12;
`ifdef DMEM_PARITY_EN
  assign pe16 = b16.par_err;
  assign pe12 = b12.par_err;
`else
  assign pe16 = 1'b0;
  assign pe12 = 1'b0;
`endif

  task automatic mon_one(input int which, input logic v, input logic [7:0] d, input logic pe);
    exp_t  e;
    bit    have;
    string tag;
    tag  = (which == 0) ? "d16" : "d12";
    have = 1'b0;
    e.data = 8'h00;
    e.par  = 1'b0;
    if (which == 0) begin
      if (q16.size() > 0) begin have = 1'b1; e = q16.pop_front(); end
    end else begin
      if (q12.size() > 0) begin have = 1'b1; e = q12.pop_front(); end
    end
    check({tag, "_rsp_valid"}, v, have);
    if (v === 1'b1 && have) begin
      check({tag, "_rsp_rdata"}, d, e.data);
`ifdef DMEM_PARITY_EN
      check({tag, "_par_err"}, pe, e.par);
`endif
    end else if (v !== 1'b1) begin
      check({tag, "_rdata_zero_when_idle"}, d, 0);
`ifdef DMEM_PARITY_EN
      check({tag, "_par_err_idle"}, pe, 0);
`endif
    end
  endtask

  // Monitor: every response is due on the negedge right after its accepting edge.
  always @(negedge clk) begin
    mon_one(0, b16.rsp_valid, b16.rsp_rdata, pe16);
    mon_one(1, b12.rsp_valid, b12.rsp_rdata, pe12);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    model_zero();

    // Reset, sweep length and all-zero contents.
    do_reset();
    for (int a = 0; a < 16; a++) issue(1'b0, 8'(a), 8'h00);
    idle(2);

    // Write then immediate read of the same address.
    issue(1'b1, 8'd3, 8'hA5);
    issue(1'b0, 8'd3, 8'h00);
    idle(1);

    // Back-to-back reads.
    issue(1'b1, 8'd1, 8'h11);
    issue(1'b1, 8'd2, 8'h22);
    issue(1'b1, 8'd3, 8'h33);
    issue(1'b0, 8'd1, 8'h00);
    issue(1'b0, 8'd2, 8'h00);
    issue(1'b0, 8'd3, 8'h00);
    idle(1);

    // Out-of-range handling around DEPTH=12 and the top of the address space.
    issue(1'b1, 8'd13,  8'hFF);
    issue(1'b1, 8'd11,  8'h5C);
    issue(1'b1, 8'd255, 8'h77);
    issue(1'b0, 8'd13,  8'h00);
    issue(1'b0, 8'd12,  8'h00);
    issue(1'b0, 8'd11,  8'h00);
    issue(1'b0, 8'd255, 8'h00);
    idle(2);

    // clr in IDLE beats a simultaneous read; then clr again at sweep cycle 5.
    issue(1'b1, 8'd3, 8'hA5);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd3, 8'h00, 1'b1);
    #1;
    check("clr_blocks_ready", {b16.req_ready, b12.req_ready}, 2'b00);
    @(posedge clk);
    model_zero();
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (5) @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    measure_busy(16, 12, "clr_restart");
    issue(1'b0, 8'd3, 8'h00);
    idle(1);

`ifdef DMEM_PARITY_EN
    // Corrupt the stored parity bit of address 4, then read it and a clean word.
    issue(1'b1, 8'd4, 8'h5A);
    issue(1'b1, 8'd5, 8'h3C);
    idle(1);
    u16.mem[4][8] = ~u16.mem[4][8];
    u12.mem[4][8] = ~u12.mem[4][8];
    bad16[4] = 1'b1;
    bad12[4] = 1'b1;
    issue(1'b0, 8'd4, 8'h00);
    issue(1'b0, 8'd5, 8'h00);
    idle(2);
`endif

    // Randomized traffic with idle gaps.
    for (int i = 0; i < 400; i++) begin
      logic       we;
      logic [7:0] a;
      logic [7:0] d;
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(240, 255))
                                       : 8'($urandom_range(0, 19));
      d  = 8'($urandom);
      issue(we, a, d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    // Reset while a read response is in flight: it is lost and the sweep reruns.
    issue(1'b1, 8'd2, 8'h9E);
    issue(1'b0, 8'd2, 8'h00);
    #2;
    rst = 1'b1;
    q16.delete();
    q12.delete();
    #1;
    check_reset_values("mid_reset");
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    model_zero();
    rst = 1'b0;
    measure_busy(16, 12, "mid_reset");
    issue(1'b0, 8'd2, 8'h00);
    issue(1'b0, 8'd3, 8'h00);
    idle(3);

    check("queue16_drained", q16.size(), 0);
    check("queue12_drained", q12.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
